// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared types and helpers for the FFT front end: complex word
//            layout, bit-reversal of a sample index, real-to-complex packing.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int C_WIDTH = 32;
    localparam int C_HALF  = C_WIDTH / 2;

    // Complex word: real part in the upper half, imaginary in the lower half
    typedef struct packed {
        logic signed [C_HALF-1:0] re;
        logic signed [C_HALF-1:0] im;
    } cplx_t;

    // Reverse the low nbits bits of idx; upper bits of the result are zero
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            r[nbits-1-i] = idx[i];
        end
        return r;
    endfunction

    // Real audio sample to complex word with a zero imaginary part
    function automatic cplx_t pack_real(input logic signed [C_HALF-1:0] sample);
        cplx_t c;
        c.re = sample;
        c.im = '0;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_frame_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_loader_if
// Purpose  : Sample-in and frame-out handshake bundle of the frame loader.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_frame_loader_if #(
    parameter int SAMPLES = 4,
    parameter int WIDTH   = 32
);
    logic                 in_valid;
    logic [WIDTH/2-1:0]   in_sample;
    logic                 in_ready;
    logic                 flush;
    logic                 frame_valid;
    logic                 frame_ready;
    logic [WIDTH-1:0]     frame_out [SAMPLES];
    logic [15:0]          frame_count;

    // Sample source / frame sink side
    modport master (
        output in_valid, in_sample, flush, frame_ready,
        input  in_ready, frame_valid, frame_out, frame_count
    );

    // Loader side
    modport slave (
        input  in_valid, in_sample, flush, frame_ready,
        output in_ready, frame_valid, frame_out, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/fft_frame_bank.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_bank
// Purpose  : One frame buffer: SAMPLES x WIDTH registers, single write port,
//            full parallel read.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_bank #(
    parameter int SAMPLES = 4,
    parameter int WIDTH   = 32,
    parameter int IDX_W   = $clog2(SAMPLES)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             we,
    input  wire logic [IDX_W-1:0] addr,
    input  wire logic [WIDTH-1:0] data,
    output logic      [WIDTH-1:0] rd_data [SAMPLES]
);

    logic [WIDTH-1:0] r_mem [SAMPLES];

    // Storage: cleared on reset so an idle output reads as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SAMPLES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[addr] <= data;
        end
    end

    assign rd_data = r_mem;

endmodule
`default_nettype wire

// File: rtl/fft_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_loader
// Purpose  : FFT front end. Packs real samples into complex words, writes
//            them at bit-reversed positions into a ping-pong frame buffer and
//            presents each completed frame in parallel to the first stage.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int SAMPLES = 4,
    parameter int WIDTH   = 32,
    parameter int IDX_W   = $clog2(SAMPLES)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fft_frame_loader_if.slave  bus
);

    logic [IDX_W-1:0] r_wr_idx;
    logic             r_wr_bank;
    logic             r_rd_bank;
    logic [1:0]       r_bank_full;
    logic [15:0]      r_frame_count;

    logic             w_in_ready;
    logic             w_frame_valid;
    logic             w_accept;
    logic             w_complete;
    logic             w_consume;
    logic [IDX_W-1:0] w_wr_addr;
    logic [WIDTH-1:0] w_wr_data;
    logic [WIDTH-1:0] w_bank_data [2][SAMPLES];

    // Ready depends on registered state only; flush blocks the write itself
    assign w_in_ready    = !r_bank_full[r_wr_bank];
    assign w_frame_valid = r_bank_full[r_rd_bank];
    assign w_accept      = bus.in_valid && w_in_ready && !bus.flush;
    assign w_complete    = w_accept && (r_wr_idx == IDX_W'(SAMPLES - 1));
    assign w_consume     = w_frame_valid && bus.frame_ready;
    assign w_wr_addr     = IDX_W'(bitrev(32'(r_wr_idx), IDX_W));

    generate
        if (WIDTH == C_WIDTH) begin : g_pack_pkg
            assign w_wr_data = pack_real(bus.in_sample);
        end else begin : g_pack_generic
            assign w_wr_data = {bus.in_sample, {(WIDTH/2){1'b0}}};
        end
    endgenerate

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            fft_frame_bank #(
                .SAMPLES (SAMPLES),
                .WIDTH   (WIDTH),
                .IDX_W   (IDX_W)
            ) u_bank (
                .clk     (clk),
                .rst_n   (rst_n),
                .we      (w_accept && (r_wr_bank == 1'(b))),
                .addr    (w_wr_addr),
                .data    (w_wr_data),
                .rd_data (w_bank_data[b])
            );
        end
    endgenerate

    generate
        for (genvar i = 0; i < SAMPLES; i++) begin : g_out
            assign bus.frame_out[i] = r_rd_bank ? w_bank_data[1][i] : w_bank_data[0][i];
        end
    endgenerate

    // Write pointer: flush restarts the frame, a completed frame wraps it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx <= '0;
        end else if (bus.flush) begin
            r_wr_idx <= '0;
        end else if (w_accept) begin
            r_wr_idx <= w_complete ? '0 : r_wr_idx + 1'b1;
        end
    end

    // Bank selection and full flags; completion and consume hit different banks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_bank_full <= 2'b00;
        end else begin
            if (w_complete) begin
                r_bank_full[r_wr_bank] <= 1'b1;
                r_wr_bank              <= !r_wr_bank;
            end
            if (w_consume) begin
                r_bank_full[r_rd_bank] <= 1'b0;
                r_rd_bank              <= !r_rd_bank;
            end
        end
    end

    // Completed-frame counter, wraps naturally at 2^16
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_count <= '0;
        end else if (w_complete) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.frame_valid = w_frame_valid;
    assign bus.frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_loader
// Purpose  : Self-checking bench for fft_frame_loader (SAMPLES=4, WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_loader;

    localparam int SAMPLES = 4;
    localparam int WIDTH   = 32;

    typedef logic [SAMPLES*WIDTH-1:0] frame_t;

    logic clk;
    logic rst_n;

    fft_frame_loader_if #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) bus ();

    fft_frame_loader #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected position of the n-th sample of a 4-point frame
    int c_br [SAMPLES] = '{0, 2, 1, 3};

    int          n_tests = 0;
    int          n_fail  = 0;
    frame_t      q_exp [$];
    logic [31:0] m_frame [SAMPLES];
    int          m_idx;
    int          m_pending;
    logic [15:0] m_count;

    function automatic frame_t obs_frame();
        return {bus.frame_out[3], bus.frame_out[2], bus.frame_out[1], bus.frame_out[0]};
    endfunction

    task automatic chk(input string tag, input logic [SAMPLES*WIDTH-1:0] obs,
                       input logic [SAMPLES*WIDTH-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idx     = 0;
        m_pending = 0;
        m_count   = 16'd0;
        q_exp.delete();
        for (int i = 0; i < SAMPLES; i++) m_frame[i] = '0;
    endtask

    // One clock: check outputs against the model, drive inputs, advance model
    task automatic tick(input logic v, input logic [15:0] s, input logic fl, input logic fr);
        logic exp_ready;
        logic exp_valid;
        exp_ready = (m_pending < 2);
        exp_valid = (m_pending > 0);
        chk("in_ready", 128'(bus.in_ready), 128'(exp_ready));
        chk("frame_valid", 128'(bus.frame_valid), 128'(exp_valid));
        chk("frame_count", 128'(bus.frame_count), 128'(m_count));
        if (exp_valid) begin
            if (q_exp.size() > 0) chk("frame_out", obs_frame(), q_exp[0]);
            else chk("scoreboard_empty", 128'(1), 128'(0));
        end
        bus.in_valid    = v;
        bus.in_sample   = s;
        bus.flush       = fl;
        bus.frame_ready = fr;
        @(posedge clk);
        if (exp_valid && fr) begin
            if (q_exp.size() > 0) void'(q_exp.pop_front());
            m_pending--;
        end
        if (fl) begin
            m_idx = 0;
        end else if (v && exp_ready) begin
            m_frame[c_br[m_idx]] = {s, 16'h0000};
            if (m_idx == SAMPLES - 1) begin
                q_exp.push_back({m_frame[3], m_frame[2], m_frame[1], m_frame[0]});
                m_pending++;
                m_count++;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        #1;
        bus.in_valid    = 1'b0;
        bus.flush       = 1'b0;
        bus.frame_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_sample   = '0;
        bus.flush       = 1'b0;
        bus.frame_ready = 1'b0;
        rst_n           = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("reset_frame_out", obs_frame(), '0);
        tick(0, 0, 0, 0);

        // Basic fill
        tick(1, 16'd10, 0, 0);
        tick(1, 16'd20, 0, 0);
        tick(1, 16'd30, 0, 0);
        tick(1, 16'd40, 0, 0);
        chk("basic_frame", obs_frame(),
            {32'h0028_0000, 32'h0014_0000, 32'h001E_0000, 32'h000A_0000});
        chk("basic_count", 128'(bus.frame_count), 128'(1));
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);

        // Ping-pong: both banks fill, then one consume frees a bank
        for (int i = 1; i <= 8; i++) tick(1, 16'(i), 0, 0);
        chk("pingpong_stall", 128'(bus.in_ready), 128'(0));
        tick(1, 16'd77, 0, 0);
        tick(0, 0, 0, 1);
        chk("pingpong_second", obs_frame(),
            {32'h0008_0000, 32'h0006_0000, 32'h0007_0000, 32'h0005_0000});
        chk("pingpong_ready", 128'(bus.in_ready), 128'(1));
        tick(0, 0, 0, 1);

        // Continuous streaming with an always-ready sink
        for (int i = 0; i < 40; i++) tick(1, 16'(100 + i), 0, 1);
        tick(0, 0, 0, 1);
        chk("continuous_count", 128'(bus.frame_count), 128'(13));

        // Flush discards the partial frame and the sample presented with it
        tick(1, 16'd10, 0, 0);
        tick(1, 16'd20, 0, 0);
        tick(1, 16'd99, 1, 0);
        for (int i = 1; i <= 4; i++) tick(1, 16'(i), 0, 0);
        chk("flush_frame", obs_frame(),
            {32'h0004_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000});
        tick(0, 0, 0, 1);

        // Flush coinciding with the last sample: bank must not be marked full
        for (int i = 1; i <= 3; i++) tick(1, 16'(50 + i), 0, 0);
        tick(1, 16'd54, 1, 0);
        tick(0, 0, 0, 0);

        // Negative full-scale sample
        tick(1, 16'h8000, 0, 0);
        tick(1, 16'd1, 0, 0);
        tick(1, 16'd2, 0, 0);
        tick(1, 16'd3, 0, 0);
        chk("negative_word0", 128'(bus.frame_out[0]), 128'(32'h8000_0000));
        tick(0, 0, 0, 1);

        // Asynchronous reset mid-frame
        tick(1, 16'd7, 0, 0);
        tick(1, 16'd8, 0, 0);
        tick(1, 16'd9, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_frame_out", obs_frame(), '0);
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_frame_valid", 128'(bus.frame_valid), 128'(0));
        chk("rst_frame_count", 128'(bus.frame_count), 128'(0));
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) tick(1, 16'(20 + i), 0, 0);
        chk("post_rst_count", 128'(bus.frame_count), 128'(1));
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
